// File: rtl/register_bank_pkg.sv
// Shared types and constants for the Flurbie architectural register file.
// Package registers_pkg: default sizing, register index/value types,
// special-register index helpers, cnvz flag bit positions and the Nop word.
package registers_pkg;

  localparam int NR_DEFAULT = 32;
  localparam int W_DEFAULT  = 32;
  localparam int IW_DEFAULT = $clog2(NR_DEFAULT);

  typedef logic [IW_DEFAULT-1:0] regind_t;
  typedef logic [W_DEFAULT-1:0]  regval_t;
  typedef regval_t               regfile_t [NR_DEFAULT];

  localparam regfile_t ZeroRegFile = '{default: '0};

  // cnvz flag bit positions inside the Flags register
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam regval_t Nop = '0;

  // The two highest registers are the architectural PC and Flags.
  function automatic int pc_index(input int nr);
    return nr - 2;
  endfunction

  function automatic int flags_index(input int nr);
    return nr - 1;
  endfunction

endpackage

// File: rtl/register_bank_if.sv
// Bus bundle between the pipeline (master) and the register bank (slave):
// read ports, general/paired write, PC/Flags update, reservation handshake.
interface register_bank_if #(
  parameter int NR  = 32,
  parameter int NRP = 3,
  parameter int W   = 32
);
  localparam int IW = $clog2(NR);

  logic [IW-1:0]  rd_index [NRP];
  logic [W-1:0]   rd_value [NRP];
  logic [NRP-1:0] busy;

  logic           wr_valid;
  logic [IW-1:0]  wr_index;
  logic [W-1:0]   wr_value;
  logic           wr_has_upper;
  logic [W-1:0]   wr_upper_value;

  logic           pc_write;
  logic [W-1:0]   pc_value;
  logic           flags_write;
  logic [3:0]     flags_value;

  logic           reserve_valid;
  logic [IW-1:0]  reserve_index;
  logic           reserve_pair;
  logic           reserve_ready;

  logic [W-1:0]   pc;
  logic [3:0]     flags;
  logic           underflow;

  modport master (
    output rd_index, wr_valid, wr_index, wr_value, wr_has_upper, wr_upper_value,
           pc_write, pc_value, flags_write, flags_value,
           reserve_valid, reserve_index, reserve_pair,
    input  rd_value, busy, reserve_ready, pc, flags, underflow
  );

  modport slave (
    input  rd_index, wr_valid, wr_index, wr_value, wr_has_upper, wr_upper_value,
           pc_write, pc_value, flags_write, flags_value,
           reserve_valid, reserve_index, reserve_pair,
    output rd_value, busy, reserve_ready, pc, flags, underflow
  );

endinterface

// File: rtl/register_bank_counter.sv
// pending_counter: CW-bit saturating up/down counter tracking outstanding
// writes to one register. A simultaneous inc and dec cancel out.
module pending_counter #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          at_max,
  output logic          underflow
);

  localparam logic [CW-1:0] MAX = '1;

  assign at_max    = (count == MAX);
  // A lone retire against an empty counter is reported, the count holds at 0
  assign underflow = dec && !inc && (count == '0);

  // Count update: saturate at both ends, cancel on simultaneous inc/dec
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + CW'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: Flurbie architectural register file with NRP combinational
// read ports, a general write port with optional paired upper write, dedicated
// PC/Flags update ports and a per-register pending-write scoreboard.
// Optional feature macro: WRITE_BYPASS_EN (same-cycle forwarding of writes to
// rd_value, and busy cleared for a register whose last pending write retires).
module register_bank
  import registers_pkg::*;
#(
  parameter int NR  = NR_DEFAULT,
  parameter int NRP = 3,
  parameter int W   = W_DEFAULT,
  parameter int CW  = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  register_bank_if.slave bus
);

  localparam int IW = $clog2(NR);
  localparam logic [IW-1:0] PC_R    = IW'(pc_index(NR));
  localparam logic [IW-1:0] FLAGS_R = IW'(flags_index(NR));
  localparam logic [IW:0]   NR_X    = (IW+1)'(NR);

  logic [W-1:0]    regs      [NR];
  logic [W-1:0]    regs_next [NR];
  logic [CW-1:0]   cnt       [NR];
  logic [NR-1:0]   inc_v;
  logic [NR-1:0]   dec_v;
  logic [NR-1:0]   at_max_v;
  logic [NR-1:0]   uf_v;
  logic [NR-1:0]   blk;
  logic            underflow_q;

  // Upper indices are one bit wider so NR-1 + 1 never wraps onto r0.
  logic [IW:0]     wr_upper_idx;
  logic [IW:0]     rs_upper_idx;
  logic            upper_ok;
  logic            rs_upper_ok;
  logic            accept;

  assign wr_upper_idx = {1'b0, bus.wr_index} + (IW+1)'(1);
  assign rs_upper_idx = {1'b0, bus.reserve_index} + (IW+1)'(1);
  assign upper_ok     = bus.wr_valid && bus.wr_has_upper && (wr_upper_idx < NR_X);
  assign rs_upper_ok  = bus.reserve_pair && (rs_upper_idx < NR_X);

  // Next register contents: general write, upper write, then PC/Flags ports win
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      regs_next[r] = regs[r];
      if (bus.wr_valid && (bus.wr_index == IW'(r))) begin
        regs_next[r] = bus.wr_value;
      end
      if (upper_ok && (wr_upper_idx == (IW+1)'(r))) begin
        regs_next[r] = bus.wr_upper_value;
      end
    end
    if (bus.pc_write) begin
      regs_next[PC_R] = bus.pc_value;
    end
    regs_next[FLAGS_R][W-1:4] = '0;
    if (bus.flags_write) begin
      regs_next[FLAGS_R][3:0] = bus.flags_value;
    end
    regs_next[0] = '0;
  end

  // Register storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NR; r++) begin
        regs[r] <= '0;
      end
    end else begin
      regs <= regs_next;
    end
  end

  // Reservation is refused if any scoreboarded target is full and not retiring
  assign bus.reserve_ready = !blk[bus.reserve_index] &&
                             !(rs_upper_ok && blk[rs_upper_idx[IW-1:0]]);
  assign accept = bus.reserve_valid && bus.reserve_ready;

  for (genvar r = 0; r < NR; r++) begin : g_sb
    if (r >= 1 && r < NR - 2) begin : g_gen
      assign inc_v[r] = accept &&
                        ((bus.reserve_index == IW'(r)) ||
                         (rs_upper_ok && (rs_upper_idx == (IW+1)'(r))));
      assign dec_v[r] = (bus.wr_valid && (bus.wr_index == IW'(r))) ||
                        (upper_ok && (wr_upper_idx == (IW+1)'(r)));
      assign blk[r]   = at_max_v[r] && !dec_v[r];

      pending_counter #(.CW(CW)) u_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc       (inc_v[r]),
        .dec       (dec_v[r]),
        .count     (cnt[r]),
        .at_max    (at_max_v[r]),
        .underflow (uf_v[r])
      );
    end else begin : g_fixed
      // r0, PC and Flags are never tracked
      assign inc_v[r]    = 1'b0;
      assign dec_v[r]    = 1'b0;
      assign blk[r]      = 1'b0;
      assign at_max_v[r] = 1'b0;
      assign uf_v[r]     = 1'b0;
      assign cnt[r]      = '0;
    end
  end

  // Sticky underflow flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
    end else if (|uf_v) begin
      underflow_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [CW-1:0] rc;
    assign rc = cnt[bus.rd_index[i]];
`ifdef WRITE_BYPASS_EN
    assign bus.rd_value[i] = regs_next[bus.rd_index[i]];
    assign bus.busy[i]     = (rc != '0) && !((rc == CW'(1)) && dec_v[bus.rd_index[i]]);
`else
    assign bus.rd_value[i] = regs[bus.rd_index[i]];
    assign bus.busy[i]     = (rc != '0);
`endif
  end

  assign bus.pc        = regs[PC_R];
  assign bus.flags     = regs[FLAGS_R][3:0];
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed testbench for register_bank with a queue-based scoreboard:
// stimulus pushes expected values, a monitor on the falling edge pops and
// compares them against the DUT outputs.
module tb_register_bank;

  localparam int NR  = 32;
  localparam int NRP = 3;
  localparam int W   = 32;
  localparam int CW  = 2;

  typedef enum int {S_RD, S_BUSY, S_PC, S_FLAGS, S_UF, S_RDY} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    int          port;
    logic [31:0] exp;
  } chk_t;

  logic clk;
  logic rst_n;
  chk_t q[$];
  int   n_tests;
  int   n_fail;

  register_bank_if #(.NR(NR), .NRP(NRP), .W(W)) bus ();

  register_bank #(.NR(NR), .NRP(NRP), .W(W), .CW(CW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sample(input sel_e s, input int p);
    case (s)
      S_RD:    return bus.rd_value[p];
      S_BUSY:  return {31'b0, bus.busy[p]};
      S_PC:    return bus.pc;
      S_FLAGS: return {28'b0, bus.flags};
      S_UF:    return {31'b0, bus.underflow};
      default: return {31'b0, bus.reserve_ready};
    endcase
  endfunction

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin : monitor
    chk_t c;
    logic [31:0] act;
    while (q.size() > 0) begin
      c   = q.pop_front();
      act = sample(c.sel, c.port);
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
      end
    end
  end

  task automatic chk(input string n, input sel_e s, input int p, input logic [31:0] v);
    q.push_back('{n, s, p, v});
  endtask

  task automatic idle();
    bus.wr_valid       = 1'b0;
    bus.wr_index       = '0;
    bus.wr_value       = '0;
    bus.wr_has_upper   = 1'b0;
    bus.wr_upper_value = '0;
    bus.pc_write       = 1'b0;
    bus.pc_value       = '0;
    bus.flags_write    = 1'b0;
    bus.flags_value    = '0;
    bus.reserve_valid  = 1'b0;
    bus.reserve_index  = '0;
    bus.reserve_pair   = 1'b0;
  endtask

  // Advance to just after the next rising edge with all strobes idle
  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int idx, input logic [31:0] v);
    bus.wr_valid = 1'b1;
    bus.wr_index = 5'(idx);
    bus.wr_value = v;
  endtask

  task automatic rsv(input int idx, input logic pair);
    bus.reserve_valid = 1'b1;
    bus.reserve_index = 5'(idx);
    bus.reserve_pair  = pair;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
    bus.rd_index[0] = 5'd5;
    bus.rd_index[1] = 5'd7;
    bus.rd_index[2] = 5'd9;

    // Reset state
    chk("rst_rd", S_RD, 0, 32'h0);
    chk("rst_busy", S_BUSY, 0, 32'h0);
    chk("rst_pc", S_PC, 0, 32'h0);
    chk("rst_flags", S_FLAGS, 0, 32'h0);
    chk("rst_ready", S_RDY, 0, 32'h1);
    chk("rst_uf", S_UF, 0, 32'h0);
    next();
    rst_n = 1'b1;

    // Reset mid-operation
    next();
    wr(5, 32'h1234);
    bus.pc_write = 1'b1;
    bus.pc_value = 32'h44;
    next();
    chk("t1_r5", S_RD, 0, 32'h1234);
    chk("t1_pc", S_PC, 0, 32'h44);
    chk("t1_uf_set", S_UF, 0, 32'h1);
    next();
    rst_n = 1'b0;
    chk("t1_r5_rst", S_RD, 0, 32'h0);
    chk("t1_pc_rst", S_PC, 0, 32'h0);
    chk("t1_uf_rst", S_UF, 0, 32'h0);
    next();
    rst_n = 1'b1;

    // Paired write
    next();
    wr(6, 32'hA);
    bus.wr_has_upper   = 1'b1;
    bus.wr_upper_value = 32'hB;
    next();
    bus.rd_index[0] = 5'd6;
    bus.rd_index[1] = 5'd7;
    chk("t2_r6", S_RD, 0, 32'hA);
    chk("t2_r7", S_RD, 1, 32'hB);
    next();
    wr(31, 32'hFFFF_FFFA);
    bus.wr_has_upper   = 1'b1;
    bus.wr_upper_value = 32'hB;
    next();
    bus.rd_index[0] = 5'd31;
    bus.rd_index[1] = 5'd0;
    chk("t2_flags", S_FLAGS, 0, 32'hA);
    chk("t2_r31_masked", S_RD, 0, 32'hA);
    chk("t2_no_wrap_r0", S_RD, 1, 32'h0);

    // r0 handling
    next();
    wr(0, 32'hFFFF);
    rsv(0, 1'b0);
    chk("t3_ready_r0", S_RDY, 0, 32'h1);
    next();
    bus.rd_index[1] = 5'd0;
    chk("t3_r0", S_RD, 1, 32'h0);
    chk("t3_busy_r0", S_BUSY, 1, 32'h0);

    // Port priority
    next();
    wr(30, 32'h200);
    bus.wr_has_upper   = 1'b1;
    bus.wr_upper_value = 32'hE;
    bus.pc_write       = 1'b1;
    bus.pc_value       = 32'h100;
    bus.flags_write    = 1'b1;
    bus.flags_value    = 4'h5;
    next();
    bus.rd_index[0] = 5'd30;
    bus.rd_index[1] = 5'd31;
    chk("t4_pc", S_PC, 0, 32'h100);
    chk("t4_flags", S_FLAGS, 0, 32'h5);
    chk("t4_rd_pc", S_RD, 0, 32'h100);
    chk("t4_rd_flags", S_RD, 1, 32'h5);

    // Scoreboard
    next();
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    bus.rd_index[0] = 5'd3;
    bus.rd_index[1] = 5'd4;
    next();
    rsv(3, 1'b0);
    chk("t5_ready0", S_RDY, 0, 32'h1);
    chk("t5_busy0", S_BUSY, 0, 32'h0);
    next();
    rsv(3, 1'b0);
    chk("t5_busy1", S_BUSY, 0, 32'h1);
    next();
    rsv(3, 1'b0);
    chk("t5_ready2", S_RDY, 0, 32'h1);
    next();
    rsv(3, 1'b1);
    chk("t5_ready_full", S_RDY, 0, 32'h0);
    chk("t5_busy_full", S_BUSY, 0, 32'h1);
    next();
    chk("t5_pair_dropped", S_BUSY, 1, 32'h0);
    chk("t5_busy3", S_BUSY, 0, 32'h1);
    next();
    wr(3, 32'h1);
    bus.reserve_index = 5'd3;
    chk("t5_ready_on_retire", S_RDY, 0, 32'h1);
    chk("t5_busy_ret1", S_BUSY, 0, 32'h1);
    next();
    wr(3, 32'h2);
    chk("t5_busy_ret2", S_BUSY, 0, 32'h1);
    next();
    wr(3, 32'h3);
`ifdef WRITE_BYPASS_EN
    chk("t5_busy_ret3", S_BUSY, 0, 32'h0);
`else
    chk("t5_busy_ret3", S_BUSY, 0, 32'h1);
`endif
    chk("t5_uf_before", S_UF, 0, 32'h0);
    next();
    chk("t5_busy_clear", S_BUSY, 0, 32'h0);
    chk("t5_uf_still0", S_UF, 0, 32'h0);
    next();
    wr(3, 32'h4);
    next();
    chk("t5_uf_set", S_UF, 0, 32'h1);
    chk("t5_r3", S_RD, 0, 32'h4);

    // Write bypass
    next();
    bus.rd_index[2] = 5'd9;
    wr(9, 32'h77);
`ifdef WRITE_BYPASS_EN
    chk("t6_same_cycle", S_RD, 2, 32'h77);
`else
    chk("t6_same_cycle", S_RD, 2, 32'h0);
`endif
    next();
    chk("t6_next_cycle", S_RD, 2, 32'h77);

    next();
    next();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
